// File: rtl/ov7670_pkg.sv
// Shared definitions for the OV7670 SCCB configuration sequencer:
// table markers, FSM state encodings and the table entry classifier.
package ov7670_pkg;

    localparam logic [7:0]  DEV_ID_DEFAULT = 8'h42;
    localparam logic [15:0] END_MARK       = 16'hFFFF;
    localparam logic [15:0] DELAY_MARK     = 16'hFFF0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_SEND,
        S_DELAY,
        S_DONE
    } state_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_BITS,
        TX_STOP,
        TX_GAP
    } tx_phase_t;

    typedef enum logic [1:0] {
        ENT_WRITE,
        ENT_DELAY,
        ENT_END
    } entry_t;

    function automatic entry_t classify(input logic [15:0] e);
        if (e == END_MARK) begin
            return ENT_END;
        end
        if (e == DELAY_MARK) begin
            return ENT_DELAY;
        end
        return ENT_WRITE;
    endfunction

endpackage

// File: rtl/ov7670_sccb_config_sccb_byte_tx.sv
// SCCB byte transmitter: quarter-bit divider, 9-bit shifter, optional
// start condition before the byte and stop condition plus idle gap after.
module sccb_byte_tx
    import ov7670_pkg::*;
#(
    parameter int QUARTER_DIV = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       go,
    input  logic [7:0] tx_byte,
    input  logic       first,
    input  logic       last,
    output logic       sio_c,
    output logic       sio_d_out,
    output logic       sio_d_oe,
    output logic       byte_done
);

    localparam int QW = (QUARTER_DIV > 1) ? $clog2(QUARTER_DIV) : 1;

    tx_phase_t  phase, phase_d;
    logic [QW-1:0] qcnt, qcnt_d;
    logic [1:0] quarter, quarter_d;
    logic [3:0] bitcnt, bitcnt_d;
    logic [8:0] shreg, shreg_d;
    logic       last_q, last_d;
    logic       tick;
    logic       byte_end;
    logic       gap_end;
    logic       load;

    assign tick     = (phase != TX_IDLE) && (qcnt == QW'(QUARTER_DIV - 1));
    assign byte_end = (phase == TX_BITS) && tick && (quarter == 2'd3)
                      && (bitcnt == 4'd8);
    assign gap_end  = (phase == TX_GAP) && tick && (quarter == 2'd3);
    assign byte_done = (byte_end && !last_q) || gap_end;
    // A following byte chains on the final tick so no idle quarter is inserted.
    assign load = go && ((phase == TX_IDLE) || (byte_end && !last_q));

    // Next phase, quarter, bit counter and shifter.
    always_comb begin
        phase_d   = phase;
        quarter_d = quarter;
        bitcnt_d  = bitcnt;
        shreg_d   = shreg;
        last_d    = last_q;
        qcnt_d    = qcnt;
        if (load) begin
            phase_d   = first ? TX_START : TX_BITS;
            quarter_d = 2'd0;
            bitcnt_d  = 4'd0;
            shreg_d   = {tx_byte, 1'b1};
            last_d    = last;
            qcnt_d    = '0;
        end else if (tick) begin
            qcnt_d    = '0;
            quarter_d = quarter + 2'd1;
            unique case (phase)
                TX_START: begin
                    if (quarter == 2'd1) begin
                        phase_d   = TX_BITS;
                        quarter_d = 2'd0;
                    end
                end
                TX_BITS: begin
                    if (quarter == 2'd3) begin
                        if (bitcnt == 4'd8) begin
                            phase_d  = last_q ? TX_STOP : TX_IDLE;
                            bitcnt_d = 4'd0;
                        end else begin
                            bitcnt_d = bitcnt + 4'd1;
                            shreg_d  = {shreg[7:0], 1'b1};
                        end
                    end
                end
                TX_STOP: begin
                    if (quarter == 2'd2) begin
                        phase_d   = TX_GAP;
                        quarter_d = 2'd0;
                    end
                end
                TX_GAP: begin
                    if (quarter == 2'd3) begin
                        phase_d = TX_IDLE;
                    end
                end
                default: begin
                    phase_d = TX_IDLE;
                end
            endcase
        end else if (phase != TX_IDLE) begin
            qcnt_d = qcnt + QW'(1);
        end else begin
            qcnt_d = '0;
        end
    end

    // Transmitter state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase   <= TX_IDLE;
            qcnt    <= '0;
            quarter <= 2'd0;
            bitcnt  <= 4'd0;
            shreg   <= 9'h1FF;
            last_q  <= 1'b0;
        end else begin
            phase   <= phase_d;
            qcnt    <= qcnt_d;
            quarter <= quarter_d;
            bitcnt  <= bitcnt_d;
            shreg   <= shreg_d;
            last_q  <= last_d;
        end
    end

    // Bus levels; a logic 1 on data is always a release, never a drive.
    always_comb begin
        sio_c    = 1'b1;
        sio_d_oe = 1'b0;
        unique case (phase)
            TX_START: begin
                sio_c    = (quarter == 2'd0);
                sio_d_oe = 1'b1;
            end
            TX_BITS: begin
                sio_c    = (quarter == 2'd1) || (quarter == 2'd2);
                sio_d_oe = !shreg[8];
            end
            TX_STOP: begin
                sio_c    = (quarter != 2'd0);
                sio_d_oe = (quarter != 2'd2);
            end
            default: begin
                sio_c    = 1'b1;
                sio_d_oe = 1'b0;
            end
        endcase
        sio_d_out = !sio_d_oe;
    end

endmodule

// File: rtl/ov7670_sccb_config.sv
// OV7670 power-up sequencer: walks the register table, issues SCCB
// 3-phase writes, honours delay entries and flags completion.
module ov7670_sccb_config
    import ov7670_pkg::*;
#(
    parameter int         QUARTER_DIV  = 250,
    parameter logic [7:0] DEV_ID       = DEV_ID_DEFAULT,
    parameter int         TABLE_AW     = 8,
    parameter int         DELAY_CYCLES = 1_000_000
) (
    input  logic                clk100,
    input  logic                rst,
    input  logic                start,
    output logic [TABLE_AW-1:0] cfg_addr,
    input  logic [15:0]         cfg_data,
    output logic                sio_c,
    output logic                sio_d_out,
    output logic                sio_d_oe,
    output logic                busy,
    output logic                done
);

    localparam int DW = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;

    state_t        state, state_d;
    entry_t        entry;
    logic [7:0]    reg_q;
    logic [7:0]    val_q;
    logic [1:0]    idx;
    logic [DW-1:0] dcnt;
    logic          last_addr;
    logic          step;
    logic          go;
    logic [7:0]    tx_byte;
    logic          first;
    logic          last;
    logic          byte_done;

    assign entry     = classify(cfg_data);
    assign last_addr = &cfg_addr;

    // Sequencer state register.
    always_ff @(posedge clk100) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state and transmitter requests; step retires the current entry.
    always_comb begin
        state_d = state;
        go      = 1'b0;
        tx_byte = DEV_ID;
        first   = 1'b0;
        last    = 1'b0;
        step    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_DECODE;
            end
            S_DECODE: begin
                unique case (entry)
                    ENT_END:   state_d = S_DONE;
                    ENT_DELAY: state_d = S_DELAY;
                    default: begin
                        state_d = S_SEND;
                        go      = 1'b1;
                        first   = 1'b1;
                        tx_byte = DEV_ID;
                    end
                endcase
            end
            S_SEND: begin
                if (byte_done) begin
                    if (idx == 2'd2) begin
                        step = 1'b1;
                    end else begin
                        go      = 1'b1;
                        tx_byte = (idx == 2'd0) ? reg_q : val_q;
                        last    = (idx == 2'd1);
                    end
                end
            end
            S_DELAY: begin
                if (dcnt == DW'(DELAY_CYCLES - 1)) begin
                    step = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // The last table slot ends the run instead of wrapping to 0.
        if (step) begin
            state_d = last_addr ? S_DONE : S_FETCH;
        end
    end

    // Table address, latched entry, byte index, delay counter and status.
    always_ff @(posedge clk100) begin
        if (rst) begin
            cfg_addr <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            reg_q    <= 8'h00;
            val_q    <= 8'h00;
            idx      <= 2'd0;
            dcnt     <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        cfg_addr <= '0;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                    end
                end
                S_DECODE: begin
                    reg_q <= cfg_data[15:8];
                    val_q <= cfg_data[7:0];
                    idx   <= 2'd0;
                    dcnt  <= '0;
                end
                S_SEND: begin
                    if (byte_done) begin
                        idx <= idx + 2'd1;
                    end
                end
                S_DELAY: begin
                    dcnt <= dcnt + DW'(1);
                end
                S_DONE: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
                default: begin
                end
            endcase
            if (step && !last_addr) begin
                cfg_addr <= cfg_addr + TABLE_AW'(1);
            end
        end
    end

    sccb_byte_tx #(
        .QUARTER_DIV(QUARTER_DIV)
    ) u_tx (
        .clk       (clk100),
        .rst       (rst),
        .go        (go),
        .tx_byte   (tx_byte),
        .first     (first),
        .last      (last),
        .sio_c     (sio_c),
        .sio_d_out (sio_d_out),
        .sio_d_oe  (sio_d_oe),
        .byte_done (byte_done)
    );

endmodule
